// File: rtl/sm_tc_conv_pipe.sv
// sm_tc_conv_pipe
//   Streaming converter between two's-complement (TC) and sign-magnitude
//   (SM) encodings, direction selected per beat. Two register stages with
//   valid/ready flow control run at one beat per clock with no bubbles.
//   S1 captures the raw beat; S2 holds the converted result and drives out_*.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        input handshake
//     in_mode                  0: TC->SM, 1: SM->TC
//     in_data [W-1:0]          operand
//     in_tag  [TAG_W-1:0]      sideband carried with the beat
//     out_valid/out_ready      output handshake
//     out_data [W-1:0]         converted result
//     out_tag  [TAG_W-1:0]     tag of the result beat
//     out_ovf                  TC->SM input was -2^(W-1), result saturated
//     out_nz                   SM->TC input was -0, result forced to 0
//     ovf_cnt [15:0]           only with SM_TC_OVF_CNT_EN: saturating count
//                              of output handshakes carrying ovf or nz
//
//   Build option: define SM_TC_OVF_CNT_EN to add the ovf_cnt port/counter.

module sm_tc_conv_pipe #(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [W-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_nz
`ifdef SM_TC_OVF_CNT_EN
    ,
    output logic [15:0]      ovf_cnt
`endif
);

    localparam logic [W-2:0] MAG_ONE = {{(W-2){1'b0}}, 1'b1};

    // S1: raw input register
    logic             s1_v_q, s1_v_d;
    logic             s1_mode_q, s1_mode_d;
    logic [W-1:0]     s1_data_q, s1_data_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // S2: result register, drives the outputs directly
    logic             s2_v_q, s2_v_d;
    logic [W-1:0]     s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_nz_q, s2_nz_d;

    logic s1_adv, s2_adv;

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    // Conversion of the S1 beat.
    logic         sgn, mag_zero;
    logic [W-2:0] mag;
    logic [W-1:0] conv_data;
    logic         conv_ovf, conv_nz;

    assign sgn      = s1_data_q[W-1];
    assign mag      = s1_data_q[W-2:0];
    assign mag_zero = (mag == '0);

    always_comb begin
        conv_data = s1_data_q;
        conv_ovf  = 1'b0;
        conv_nz   = 1'b0;
        if (sgn) begin
            if (!s1_mode_q) begin
                // TC->SM: magnitude is the negation of the low bits; the most
                // negative value has no SM form and saturates to -(2^(W-1)-1).
                if (mag_zero) begin
                    conv_data = {1'b1, {(W-1){1'b1}}};
                    conv_ovf  = 1'b1;
                end else begin
                    conv_data = {1'b1, (~mag) + MAG_ONE};
                end
            end else begin
                // SM->TC: -0 has no TC form and collapses to +0.
                if (mag_zero) begin
                    conv_data = '0;
                    conv_nz   = 1'b1;
                end else begin
                    conv_data = {1'b1, ~(mag - MAG_ONE)};
                end
            end
        end
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_mode_d = s1_mode_q;
        s1_data_d = s1_data_q;
        s1_tag_d  = s1_tag_q;
        if (s1_adv) begin
            s1_v_d = in_valid;
            // Payload only captured for real beats so idle inputs are ignored.
            if (in_valid) begin
                s1_mode_d = in_mode;
                s1_data_d = in_data;
                s1_tag_d  = in_tag;
            end
        end
    end

    always_comb begin
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        s2_ovf_d  = s2_ovf_q;
        s2_nz_d   = s2_nz_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            // Outputs hold their last result while no new beat arrives.
            if (s1_v_q) begin
                s2_data_d = conv_data;
                s2_tag_d  = s1_tag_q;
                s2_ovf_d  = conv_ovf;
                s2_nz_d   = conv_nz;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_mode_q <= 1'b0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
            s2_ovf_q  <= 1'b0;
            s2_nz_q   <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_mode_q <= s1_mode_d;
            s1_data_q <= s1_data_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
            s2_ovf_q  <= s2_ovf_d;
            s2_nz_q   <= s2_nz_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;
    assign out_ovf   = s2_ovf_q;
    assign out_nz    = s2_nz_q;

`ifdef SM_TC_OVF_CNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    // Counted on the handshake so a stalled beat is counted exactly once.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (s2_v_q && out_ready && (s2_ovf_q || s2_nz_q) && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sm_tc_conv_pipe.sv
// Directed bench for sm_tc_conv_pipe (W=32, TAG_W=4). A negedge monitor
// pops hand-computed expected beats on each output handshake and checks
// payload, order, latency and stall stability.
module tb_sm_tc_conv_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mode;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_ovf, out_nz;
`ifdef SM_TC_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    sm_tc_conv_pipe #(.W(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_nz    (out_nz)
`ifdef SM_TC_OVF_CNT_EN
        ,
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        logic        o;
        logic        n;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];

    // Offer one beat and hold it until accepted (bounded).
    task automatic send(input logic m, input logic [31:0] d, input logic [3:0] t,
                        input logic [31:0] ed, input logic eo, input logic en,
                        input bit push, input bit lat, output int waits);
        bit acc;
        acc      = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        else if (push) exp_q.push_back('{ed, t, eo, en, cyc, lat});
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_mode  = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor
    bit          prev_stall = 1'b0;
    logic [31:0] pd;
    logic [3:0]  pt;
    logic        po, pn;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(pd));
                chk("stall_tag_flags", 64'({out_tag, out_ovf, out_nz}), 64'({pt, po, pn}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 64'(out_data), 64'(e.d));
                    chk("tag", 64'(out_tag), 64'(e.t));
                    chk("ovf", 64'(out_ovf), 64'(e.o));
                    chk("nz", 64'(out_nz), 64'(e.n));
                    // Result registered one edge after the accepting edge,
                    // i.e. two edges counted from the beat's presentation.
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd1);
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pt = out_tag;
            po = out_ovf;
            pn = out_nz;
        end
    end

    int w;
    int w0, w1, w2, w3;

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle();
        in_tag    = 4'h0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag_flags", 64'({out_tag, out_ovf, out_nz}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SM_TC_OVF_CNT_EN
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // 1: TC->SM back-to-back
        send(1'b0, 32'hFFFF_FFFF, 4'h1, 32'h8000_0001, 1'b0, 1'b0, 1, 1, w);
        send(1'b0, 32'h0000_0005, 4'h2, 32'h0000_0005, 1'b0, 1'b0, 1, 1, w);
        send(1'b0, 32'h8000_0000, 4'h3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1, w);
        idle();
        drain();

        // 2: SM->TC
        send(1'b1, 32'h8000_0001, 4'h4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1, w);
        send(1'b1, 32'h7FFF_FFFF, 4'h5, 32'h7FFF_FFFF, 1'b0, 1'b0, 1, 1, w);
        send(1'b1, 32'h8000_0000, 4'h6, 32'h0000_0000, 1'b0, 1'b1, 1, 1, w);
        idle();
        drain();

        // 3: alternating modes, streaming, no bubbles
        send(1'b0, 32'hFFFF_FFFE, 4'h0, 32'h8000_0002, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy0", 64'(w), 64'd0);
        send(1'b1, 32'h8000_0002, 4'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy1", 64'(w), 64'd0);
        send(1'b0, 32'h1234_5678, 4'h2, 32'h1234_5678, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy2", 64'(w), 64'd0);
        send(1'b1, 32'h0000_0000, 4'h3, 32'h0000_0000, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy3", 64'(w), 64'd0);
        send(1'b0, 32'h8000_0001, 4'h4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy4", 64'(w), 64'd0);
        send(1'b1, 32'hFFFF_FFFF, 4'h5, 32'h8000_0001, 1'b0, 1'b0, 1, 1, w); chk("t3_rdy5", 64'(w), 64'd0);
        send(1'b0, 32'h8000_0000, 4'h6, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1, w); chk("t3_rdy6", 64'(w), 64'd0);
        send(1'b1, 32'h8000_0000, 4'h7, 32'h0000_0000, 1'b0, 1'b1, 1, 1, w); chk("t3_rdy7", 64'(w), 64'd0);
        idle();
        drain();

        // 4: output stalled for 5 clocks while 4 beats are offered
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 32'hFFFF_FFFD, 4'h8, 32'h8000_0003, 1'b0, 1'b0, 1, 0, w0);
                send(1'b1, 32'h8000_0003, 4'h9, 32'hFFFF_FFFD, 1'b0, 1'b0, 1, 0, w1);
                in_data = 32'h0000_0042;
                in_mode = 1'b0;
                in_tag  = 4'hA;
                #1;
                chk("t4_in_ready_low", 64'(in_ready), 64'd0);
                send(1'b0, 32'h0000_0042, 4'hA, 32'h0000_0042, 1'b0, 1'b0, 1, 0, w2);
                send(1'b1, 32'h8000_0000, 4'hB, 32'h0000_0000, 1'b0, 1'b1, 1, 0, w3);
                idle();
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("t4_acc_no_wait", 64'(w0 + w1), 64'd0);
        chk("t4_third_waited", 64'(w2 > 0), 64'd1);
        drain();

        // 5: asynchronous reset with both stages full
        out_ready = 1'b0;
        send(1'b0, 32'h0000_1111, 4'hC, 32'h0, 1'b0, 1'b0, 0, 0, w);
        send(1'b0, 32'h0000_2222, 4'hD, 32'h0, 1'b0, 1'b0, 0, 0, w);
        idle();
        @(negedge clk);
        chk("t5_full_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_data", 64'(out_data), 64'd0);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 32'hFFFF_FFF0, 4'hE, 32'h8000_0010, 1'b0, 1'b0, 1, 1, w);
        idle();
        drain();

`ifdef SM_TC_OVF_CNT_EN
        // 6: saturation/zero-flag counter, one ovf beat stalled 3 clocks
        chk("t6_cnt_start", 64'(ovf_cnt), 64'd0);
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 32'h8000_0000, 4'h1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0, w);
                send(1'b1, 32'h8000_0000, 4'h2, 32'h0000_0000, 1'b0, 1'b1, 1, 0, w);
                send(1'b0, 32'h8000_0000, 4'h3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0, w);
                send(1'b1, 32'h8000_0000, 4'h4, 32'h0000_0000, 1'b0, 1'b1, 1, 0, w);
                send(1'b0, 32'h8000_0000, 4'h5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 0, w);
                idle();
            end
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid && out_ovf;
                end
                if (!seen) chk("t6_ovf_seen", 64'(seen), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("t6_ovf_cnt", 64'(ovf_cnt), 64'd5);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
